// File: rtl/rr_distributor.sv
// Round-robin fan-out: one decoupled input stream is spread over four
// decoupled consumers through a single-entry holding register.
module rr_distributor #(
  parameter int W     = 8,
  parameter int N_OUT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         io_in_valid,
  output logic         io_in_ready,
  input  logic [W-1:0] io_in_bits,
  output logic         io_out_0_valid,
  input  logic         io_out_0_ready,
  output logic [W-1:0] io_out_0_bits,
  output logic         io_out_1_valid,
  input  logic         io_out_1_ready,
  output logic [W-1:0] io_out_1_bits,
  output logic         io_out_2_valid,
  input  logic         io_out_2_ready,
  output logic [W-1:0] io_out_2_bits,
  output logic         io_out_3_valid,
  input  logic         io_out_3_ready,
  output logic [W-1:0] io_out_3_bits,
  output logic [1:0]   io_sel,
  output logic         io_fire
);

  logic             buf_valid;
  logic [W-1:0]     buf_bits;
  logic [1:0]       last_grant;
  logic [1:0]       sel;
  logic             found;
  logic             out_fire;
  logic             in_fire;
  logic [N_OUT-1:0] rdy;
  logic [N_OUT-1:0] vld;

  assign rdy = {io_out_3_ready, io_out_2_ready, io_out_1_ready, io_out_0_ready};

  // First pass looks above last_grant, second pass wraps; with nobody
  // ready the selection parks on the port after the last grant.
  always_comb begin
    sel   = last_grant + 2'd1;
    found = 1'b0;
    for (int k = 0; k < N_OUT; k++) begin
      if (!found && rdy[k] && (3'(k) > {1'b0, last_grant})) begin
        sel   = 2'(k);
        found = 1'b1;
      end
    end
    for (int k = 0; k < N_OUT; k++) begin
      if (!found && rdy[k]) begin
        sel   = 2'(k);
        found = 1'b1;
      end
    end
  end

  genvar k;
  generate
    for (k = 0; k < N_OUT; k++) begin : g_vld
      assign vld[k] = buf_valid & (sel == 2'(k));
    end
  endgenerate

  assign out_fire    = buf_valid & rdy[sel];
  // buf_valid is already cleared asynchronously; reset only needs to gate ready.
  assign io_in_ready = reset & (~buf_valid | out_fire);
  assign in_fire     = io_in_valid & io_in_ready;

  assign io_out_0_valid = vld[0];
  assign io_out_1_valid = vld[1];
  assign io_out_2_valid = vld[2];
  assign io_out_3_valid = vld[3];
  assign io_out_0_bits  = buf_bits;
  assign io_out_1_bits  = buf_bits;
  assign io_out_2_bits  = buf_bits;
  assign io_out_3_bits  = buf_bits;
  assign io_sel         = sel;
  assign io_fire        = out_fire;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_valid  <= 1'b0;
      buf_bits   <= '0;
      last_grant <= 2'd3;
    end else begin
      if (out_fire) last_grant <= sel;
      if (in_fire) begin
        buf_bits  <= io_in_bits;
        buf_valid <= 1'b1;
      end else if (out_fire) begin
        buf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rr_distributor.sv
// Self-checking bench for rr_distributor: directed vector table, hand-written
// corner sequences, and random traffic against a queue-based reference model.
module tb_rr_distributor;

  logic       clk, reset;
  logic       io_in_valid, io_in_ready;
  logic [7:0] io_in_bits;
  logic       io_out_0_valid, io_out_1_valid, io_out_2_valid, io_out_3_valid;
  logic       io_out_0_ready, io_out_1_ready, io_out_2_ready, io_out_3_ready;
  logic [7:0] io_out_0_bits, io_out_1_bits, io_out_2_bits, io_out_3_bits;
  logic [1:0] io_sel;
  logic       io_fire;

  rr_distributor #(.W(8), .N_OUT(4)) dut (
    .clk(clk), .reset(reset),
    .io_in_valid(io_in_valid), .io_in_ready(io_in_ready), .io_in_bits(io_in_bits),
    .io_out_0_valid(io_out_0_valid), .io_out_0_ready(io_out_0_ready), .io_out_0_bits(io_out_0_bits),
    .io_out_1_valid(io_out_1_valid), .io_out_1_ready(io_out_1_ready), .io_out_1_bits(io_out_1_bits),
    .io_out_2_valid(io_out_2_valid), .io_out_2_ready(io_out_2_ready), .io_out_2_bits(io_out_2_bits),
    .io_out_3_valid(io_out_3_valid), .io_out_3_ready(io_out_3_ready), .io_out_3_bits(io_out_3_bits),
    .io_sel(io_sel), .io_fire(io_fire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]      dut_v;
  logic [3:0][7:0] dut_b;
  assign dut_v = {io_out_3_valid, io_out_2_valid, io_out_1_valid, io_out_0_valid};
  assign dut_b = {io_out_3_bits, io_out_2_bits, io_out_1_bits, io_out_0_bits};

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] ib, input logic [3:0] r);
    io_in_valid    = iv;
    io_in_bits     = ib;
    io_out_0_ready = r[0];
    io_out_1_ready = r[1];
    io_out_2_ready = r[2];
    io_out_3_ready = r[3];
  endtask

  task automatic vec_check(input string name, input logic ir, input logic [3:0] v,
                           input logic [1:0] s, input logic f, input logic [7:0] b);
    check({name, ".in_ready"}, 32'(io_in_ready), 32'(ir));
    check({name, ".valid"},    32'(dut_v),       32'(v));
    check({name, ".sel"},      32'(io_sel),      32'(s));
    check({name, ".fire"},     32'(io_fire),     32'(f));
    if (v != 4'h0) check({name, ".bits"}, 32'(dut_b[s]), 32'(b));
  endtask

  // Drive at posedge+1, sample at posedge+6, advance to next posedge+1.
  task automatic row(input string name, input logic iv, input logic [7:0] ib, input logic [3:0] r,
                     input logic ir, input logic [3:0] v, input logic [1:0] s,
                     input logic f, input logic [7:0] b);
    drive(iv, ib, r);
    #5;
    vec_check(name, ir, v, s, f, b);
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input string name);
    drive(1'b0, 8'h00, 4'h0);
    reset = 1'b0;
    #1;
    check({name, ".rst_valid"},    32'(dut_v),       32'h0);
    check({name, ".rst_in_ready"}, 32'(io_in_ready), 32'h0);
    check({name, ".rst_fire"},     32'(io_fire),     32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  // Reference model: buffer is a queue of at most one word; selection is a
  // rotating search starting one past the last granted port.
  logic [7:0] mq[$];
  logic [1:0] mlg;
  int         ndeliv;

  function automatic logic [1:0] pick(input logic [3:0] r, input logic [1:0] lg);
    for (int i = 1; i <= 4; i++) begin
      int p;
      p = (int'(lg) + i) % 4;
      if (r[p]) return 2'(p);
    end
    return 2'((int'(lg) + 1) % 4);
  endfunction

  task automatic model_reset();
    mq.delete();
    mlg    = 2'd3;
    ndeliv = 0;
  endtask

  task automatic mcycle(input string name, input logic iv, input logic [7:0] ib,
                        input logic [3:0] r, output logic acc);
    logic [1:0] s;
    logic       full, f, ir;
    logic [3:0] v;
    logic [7:0] b;
    full = (mq.size() != 0);
    s    = pick(r, mlg);
    f    = full && r[s];
    ir   = !full || f;
    v    = full ? 4'(1 << s) : 4'h0;
    b    = full ? mq[0] : 8'h00;
    drive(iv, ib, r);
    #5;
    vec_check(name, ir, v, s, f, b);
    if (f) begin
      mlg = s;
      void'(mq.pop_front());
      ndeliv++;
    end
    acc = iv && ir;
    if (acc) mq.push_back(ib);
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] ib;
    logic [3:0] rdy;
    logic       ir;
    logic [3:0] v;
    logic [1:0] sel;
    logic       fire;
    logic [7:0] bits;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic acc;
    int   sent;

    // streaming through all-ready ports, then single ready port 2
    tbl[0]  = '{1'b1, 8'h11, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 8'h00};
    tbl[1]  = '{1'b1, 8'h22, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 8'h11};
    tbl[2]  = '{1'b1, 8'h33, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 8'h22};
    tbl[3]  = '{1'b1, 8'h44, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1, 8'h33};
    tbl[4]  = '{1'b1, 8'h55, 4'hF, 1'b1, 4'h8, 2'd3, 1'b1, 8'h44};
    tbl[5]  = '{1'b0, 8'h00, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 8'h55};
    tbl[6]  = '{1'b0, 8'h00, 4'hF, 1'b1, 4'h0, 2'd1, 1'b0, 8'h00};
    tbl[7]  = '{1'b1, 8'hA0, 4'h4, 1'b1, 4'h0, 2'd2, 1'b0, 8'h00};
    tbl[8]  = '{1'b1, 8'hA1, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA0};
    tbl[9]  = '{1'b0, 8'h00, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1, 8'hA1};
    tbl[10] = '{1'b0, 8'h00, 4'h4, 1'b1, 4'h0, 2'd2, 1'b0, 8'h00};

    reset = 1'b1;
    drive(1'b0, 8'h00, 4'h0);
    #2;
    do_reset("init");

    for (int i = 0; i < 11; i++)
      row($sformatf("tbl%0d", i), tbl[i].iv, tbl[i].ib, tbl[i].rdy,
          tbl[i].ir, tbl[i].v, tbl[i].sel, tbl[i].fire, tbl[i].bits);

    // nobody ready: word parks on port 0, then port 1 raises ready and takes it
    do_reset("s3");
    row("s3a", 1'b1, 8'h5A, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 8'h00);
    row("s3b", 1'b0, 8'h00, 4'h0, 1'b0, 4'h1, 2'd0, 1'b0, 8'h5A);
    row("s3c", 1'b0, 8'h00, 4'h2, 1'b1, 4'h2, 2'd1, 1'b1, 8'h5A);

    // last_grant=1 with ports 0,1 ready: wrap to 0, then 1
    row("s4a", 1'b1, 8'h77, 4'h3, 1'b1, 4'h0, 2'd0, 1'b0, 8'h00);
    row("s4b", 1'b1, 8'h78, 4'h3, 1'b1, 4'h1, 2'd0, 1'b1, 8'h77);
    row("s4c", 1'b0, 8'h00, 4'h3, 1'b1, 4'h2, 2'd1, 1'b1, 8'h78);

    // reset in the middle of a held word
    row("s5a", 1'b1, 8'hC3, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 8'h00);
    drive(1'b0, 8'h00, 4'h0);
    #2;
    check("s5.held_valid", 32'(dut_v), 32'h4);
    reset = 1'b0;
    #1;
    check("s5.rst_valid",    32'(dut_v),       32'h0);
    check("s5.rst_in_ready", 32'(io_in_ready), 32'h0);
    check("s5.rst_fire",     32'(io_fire),     32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    row("s5b", 1'b1, 8'hD1, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 8'h00);
    row("s5c", 1'b0, 8'h00, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 8'hD1);

    // port 3 ready only on odd cycles, four words
    do_reset("s6");
    model_reset();
    sent = 0;
    for (int c = 0; c < 40 && (sent < 4 || mq.size() != 0); c++) begin
      mcycle("s6", sent < 4, 8'hE0 + 8'(sent), (c % 2 == 1) ? 4'h8 : 4'h0, acc);
      if (acc) sent++;
    end
    check("s6.sent",      32'(sent),   32'd4);
    check("s6.delivered", 32'(ndeliv), 32'd4);

    // random traffic
    do_reset("rnd");
    model_reset();
    sent = 0;
    for (int c = 0; c < 400; c++) begin
      mcycle("rnd", 1'($urandom), 8'($urandom), 4'($urandom), acc);
      if (acc) sent++;
    end
    check("rnd.conserve", 32'(sent), 32'(ndeliv + mq.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
